// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Selects and registers ALU operand 2. The source code picks between the
//   forwarded RY register value, a small set of constants and several
//   sign/zero-extended immediate fields. The output register honours
//   flush (highest priority), then stall (hold), then a normal load.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in_valid      decode stage presents a valid instruction
//   stall         hold the stage contents
//   flush         kill the stage contents
//   ALU_Src2      operand-2 source code
//   data_ry       register-file read port RY
//   imm_raw       raw 11-bit immediate field
//   fwd_sel       forwarding select for RY (00 rf, 01 ex/mem, 10 mem/wb, 11 ex/mem)
//   exmem_result  EX/MEM forwarding data
//   memwb_result  MEM/WB forwarding data
//   out_valid     Src2 holds a live operand
//   Src2          registered operand 2
//   src_is_imm    registered flag: Src2 came from an immediate
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [SEL_W-1:0]  ALU_Src2,
  input  logic [DATA_W-1:0] data_ry,
  input  logic [10:0]       imm_raw,
  input  logic [1:0]        fwd_sel,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] Src2,
  output logic              src_is_imm
);

  localparam logic [SEL_W-1:0] CODE_RY     = SEL_W'(8'h06);
  localparam logic [SEL_W-1:0] CODE_ZERO   = SEL_W'(8'h10);
  localparam logic [SEL_W-1:0] CODE_S_IMM4 = SEL_W'(8'h14);
  localparam logic [SEL_W-1:0] CODE_S_IMM5 = SEL_W'(8'h15);
  localparam logic [SEL_W-1:0] CODE_S_IMM8 = SEL_W'(8'h16);
  localparam logic [SEL_W-1:0] CODE_Z_IMM8 = SEL_W'(8'h17);
  localparam logic [SEL_W-1:0] CODE_SHAMT  = SEL_W'(8'h18);
  localparam logic [SEL_W-1:0] CODE_ONE    = SEL_W'(8'h26);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic              src_is_imm_q, src_is_imm_d;

  logic [DATA_W-1:0] ry_fwd;
  logic [DATA_W-1:0] sel_val;
  logic              sel_imm;
  logic [3:0]        shamt;

  // Bits [10:8] of the immediate are not used by any source code.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_raw[10:8];

  // A zero shift-amount field encodes a shift of 8.
  assign shamt = (imm_raw[4:2] == 3'd0) ? 4'd8 : {1'b0, imm_raw[4:2]};

  always_comb begin
    ry_fwd = data_ry;
    unique case (fwd_sel)
      2'b00:   ry_fwd = data_ry;
      2'b10:   ry_fwd = memwb_result;
      default: ry_fwd = exmem_result;  // 01 and 11: newest value wins
    endcase
  end

  always_comb begin
    sel_val = '0;
    sel_imm = 1'b0;
    case (ALU_Src2)
      CODE_RY:     sel_val = ry_fwd;
      CODE_ZERO:   sel_val = '0;
      CODE_S_IMM4: begin
        sel_val = DATA_W'($signed(imm_raw[3:0]));
        sel_imm = 1'b1;
      end
      CODE_S_IMM5: begin
        sel_val = DATA_W'($signed(imm_raw[4:0]));
        sel_imm = 1'b1;
      end
      CODE_S_IMM8: begin
        sel_val = DATA_W'($signed(imm_raw[7:0]));
        sel_imm = 1'b1;
      end
      CODE_Z_IMM8: begin
        sel_val = DATA_W'(imm_raw[7:0]);
        sel_imm = 1'b1;
      end
      CODE_SHAMT:  begin
        sel_val = DATA_W'(shamt);
        sel_imm = 1'b1;
      end
      CODE_ONE:    sel_val = DATA_W'(1);
      default: begin
        sel_val = '0;
        sel_imm = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    src2_d       = src2_q;
    src_is_imm_d = src_is_imm_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      src2_d       = '0;
      src_is_imm_d = 1'b0;
    end else if (!stall) begin
      out_valid_d  = in_valid;
      // A bubble loads zeros so a dead slot never carries stale data.
      src2_d       = in_valid ? sel_val : '0;
      src_is_imm_d = in_valid & sel_imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      src2_q       <= '0;
      src_is_imm_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      src2_q       <= src2_d;
      src_is_imm_q <= src_is_imm_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign Src2       = src2_q;
  assign src_is_imm = src_is_imm_q;

endmodule
